mem_access_stage: RTL and testbench



---
 rtl/mem_access_stage_pkg.sv | 59 +++++
 rtl/mem_access_stage_if.sv | 24 ++
 rtl/mem_access_stage_load_align.sv | 34 +++
 rtl/mem_access_stage.sv | 125 ++++++++++++
 tb/tb_mem_access_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// rv32_mem_pkg: shared definitions for the RV32I memory-access stage.
//   - funct3 load/store encodings
//   - FSM state enum
//   - byte-enable constants and small lane helpers (byte enables,
//     store-data lane replication, misalignment test)
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } mem_state_e;

  // Byte enables for an access of size funct3[1:0] at byte offset off.
  // Halves only look at off[1] and words ignore off, so a misaligned
  // address is silently truncated to its natural boundary.
  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = BE_BYTE << off;
      2'b01:   be = BE_HALF << {off[1], 1'b0};
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  // Replicate store data across all lanes so the memory only needs be.
  function automatic logic [31:0] wdata_rep(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic m;
    case (f3[1:0])
      2'b01:   m = off[0];
      2'b10:   m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: single-outstanding request/grant/response data bus.
//   master (memory stage): drives dbus_req/we/addr/wdata/be,
//                          receives dbus_gnt/rvalid/rdata
//   slave  (memory side) : the reverse
interface mem_access_stage_if #(parameter int XLEN = 32);
  logic            dbus_req;
  logic            dbus_we;
  logic [XLEN-1:0] dbus_addr;
  logic [XLEN-1:0] dbus_wdata;
  logic [3:0]      dbus_be;
  logic            dbus_gnt;
  logic            dbus_rvalid;
  logic [XLEN-1:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    input  dbus_gnt, dbus_rvalid, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    output dbus_gnt, dbus_rvalid, dbus_rdata
  );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// load_align: combinational load-data lane select and sign/zero extension.
//   funct3_i : registered load funct3 (size in [1:0], unsigned in [2])
//   off_i    : registered byte offset addr_q[1:0]
//   rdata_i  : raw bus read word
//   data_o   : aligned, extended load result
module load_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    data_o   = rdata_i;
    case (off_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i[1:0])
      2'b00:   data_o = {{24{byte_sel[7]  & ~funct3_i[2]}}, byte_sel};
      2'b01:   data_o = {{16{half_sel[15] & ~funct3_i[2]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I MEM stage, turns a load/store into one
// request/grant/response transaction on the data bus.
//   clk, rst           : clock, synchronous active-high reset
//   memread_mem/...    : EX/MEM access fields (read, write, funct3, addr, wdata)
//   mem_flush          : kill the access in MEM
//   dbus               : data bus master port
//   dmemrd_mem         : aligned load result, valid only in WAIT with rvalid
//   mem_stall          : freeze IF..EX/MEM (also flushes MEM/WB)
//   misalign_mem       : misaligned access flag
// Optional feature: MEM_MISALIGN_TRAP_EN enables misaligned-access detection;
// otherwise misalign_mem is 0 and low address bits are truncated.
module mem_access_stage
  import rv32_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            memread_mem,
  input  logic            memwrite_mem,
  input  logic [2:0]      funct3_mem,
  input  logic [XLEN-1:0] aluresult_mem,
  input  logic [XLEN-1:0] wdata_mem,
  input  logic            mem_flush,
  mem_access_stage_if.master dbus,
  output logic [XLEN-1:0] dmemrd_mem,
  output logic            mem_stall,
  output logic            misalign_mem
);
  mem_state_e      state_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      be_q;
  logic [2:0]      funct3_q;

  logic            access, mis, issue;
  logic [XLEN-1:0] aligned;

  load_align u_align (
    .funct3_i (funct3_q),
    .off_i    (addr_q[1:0]),
    .rdata_i  (dbus.dbus_rdata),
    .data_o   (aligned)
  );

  always_comb begin
    access = memread_mem | memwrite_mem;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (state_q == S_IDLE) & access & ~mem_flush &
          misaligned(funct3_mem, aluresult_mem[1:0]);
`else
    mis = 1'b0;
`endif
    issue = (state_q == S_IDLE) & access & ~mem_flush & ~mis;
    misalign_mem = mis;

    // IDLE issues straight from EX/MEM; REQ replays the latched copy so the
    // fields stay stable until granted.
    dbus.dbus_req   = 1'b0;
    dbus.dbus_we    = 1'b0;
    dbus.dbus_addr  = '0;
    dbus.dbus_wdata = '0;
    dbus.dbus_be    = 4'b0000;
    if (issue) begin
      dbus.dbus_req   = 1'b1;
      dbus.dbus_we    = memwrite_mem;  // read+write together counts as a store
      dbus.dbus_addr  = {aluresult_mem[XLEN-1:2], 2'b00};
      dbus.dbus_wdata = wdata_rep(funct3_mem, wdata_mem);
      dbus.dbus_be    = be_gen(funct3_mem, aluresult_mem[1:0]);
    end else if (state_q == S_REQ && !mem_flush) begin
      dbus.dbus_req   = 1'b1;
      dbus.dbus_we    = we_q;
      dbus.dbus_addr  = {addr_q[XLEN-1:2], 2'b00};
      dbus.dbus_wdata = wdata_q;
      dbus.dbus_be    = be_q;
    end

    mem_stall = (issue & ~(dbus.dbus_gnt & memwrite_mem)) |
                (state_q == S_REQ) |
                ((state_q == S_WAIT) & ~dbus.dbus_rvalid) |
                (state_q == S_DRAIN);

    // A flush arriving with the data kills the result as well.
    dmemrd_mem = ((state_q == S_WAIT) & dbus.dbus_rvalid & ~mem_flush) ? aligned : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'b0000;
      funct3_q <= 3'b000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            we_q     <= memwrite_mem;
            addr_q   <= aluresult_mem;
            wdata_q  <= wdata_rep(funct3_mem, wdata_mem);
            be_q     <= be_gen(funct3_mem, aluresult_mem[1:0]);
            funct3_q <= funct3_mem;
            if (!dbus.dbus_gnt)   state_q <= S_REQ;
            else if (!memwrite_mem) state_q <= S_WAIT;
          end
        end
        S_REQ: begin
          if (mem_flush)           state_q <= S_IDLE;
          else if (dbus.dbus_gnt)  state_q <= we_q ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          // The read is already in flight; a flush must still swallow it.
          if (dbus.dbus_rvalid)    state_q <= S_IDLE;
          else if (mem_flush)      state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (dbus.dbus_rvalid)    state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        memread_mem, memwrite_mem, mem_flush;
  logic [2:0]  funct3_mem;
  logic [31:0] aluresult_mem, wdata_mem;
  logic [31:0] dmemrd_mem;
  logic        mem_stall, misalign_mem;

  int checks = 0;
  int errors = 0;

  mem_access_stage_if #(.XLEN(32)) dbus();

  mem_access_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .memread_mem(memread_mem), .memwrite_mem(memwrite_mem),
    .funct3_mem(funct3_mem), .aluresult_mem(aluresult_mem),
    .wdata_mem(wdata_mem), .mem_flush(mem_flush),
    .dbus(dbus),
    .dmemrd_mem(dmemrd_mem), .mem_stall(mem_stall), .misalign_mem(misalign_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, naturally aligned offset.
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction
  function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
    return int'(a[1:0]) & ~(m_size(f3) - 1);
  endfunction
  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int mask = (1 << m_size(f3)) - 1;
    return 4'(mask << m_off(f3, a));
  endfunction
  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = d[(b % m_size(f3))*8 +: 8];
    return r;
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v = rd >> (8 * m_off(f3, a));
    int sz = m_size(f3);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic idle_inputs();
    memread_mem = 0; memwrite_mem = 0; mem_flush = 0;
    funct3_mem = 3'b000; aluresult_mem = 0; wdata_mem = 0;
    dbus.dbus_gnt = 0; dbus.dbus_rvalid = 0; dbus.dbus_rdata = 0;
  endtask

  // One transaction: gnt g cycles after issue, rvalid r cycles after gnt.
  task automatic run_txn(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int g, input int r, input logic [31:0] rd,
                         output logic [31:0] got);
    int last = st ? g : g + r;
    int stalls = 0;
    int exp_stalls = st ? ((g == 0) ? 0 : g + 1) : g + r;
    got = 0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (c == 0) begin
        memread_mem = ~st; memwrite_mem = st; funct3_mem = f3;
        aluresult_mem = a; wdata_mem = wd;
      end
      dbus.dbus_gnt    = (c == g);
      dbus.dbus_rvalid = !st && (c == g + r);
      dbus.dbus_rdata  = dbus.dbus_rvalid ? rd : $urandom;
      #1;
      if (mem_stall) stalls++;
      if (c == 0) chk({tag, ".misalign"}, {31'b0, misalign_mem}, 0);
      if (c <= g) begin
        chk({tag, ".req"}, {31'b0, dbus.dbus_req}, 1);
        chk({tag, ".we"},  {31'b0, dbus.dbus_we}, {31'b0, st});
        chk({tag, ".addr"}, dbus.dbus_addr, a & 32'hFFFF_FFFC);
        chk({tag, ".be"}, {28'b0, dbus.dbus_be}, {28'b0, m_be(f3, a)});
        if (st) chk({tag, ".wdata"}, dbus.dbus_wdata, m_wdata(f3, wd));
      end else begin
        chk({tag, ".req_off"}, {31'b0, dbus.dbus_req}, 0);
      end
      if (!st && c == g + r) begin
        got = dmemrd_mem;
        chk({tag, ".rdata"}, dmemrd_mem, m_load(f3, a, rd));
      end else begin
        chk({tag, ".rd_zero"}, dmemrd_mem, 0);
      end
    end
    chk({tag, ".stalls"}, stalls, exp_stalls);
    @(negedge clk);
    idle_inputs();
    #1;
    chk({tag, ".after_stall"}, {31'b0, mem_stall}, 0);
    chk({tag, ".after_req"}, {31'b0, dbus.dbus_req}, 0);
  endtask

  logic [2:0]  ops_f3 [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010};
  logic        ops_st [8] = '{0, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    logic [31:0] got;
    int stalls;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset.req", {31'b0, dbus.dbus_req}, 0);
    chk("reset.be", {28'b0, dbus.dbus_be}, 0);
    chk("reset.addr", dbus.dbus_addr, 0);
    chk("reset.stall", {31'b0, mem_stall}, 0);
    chk("reset.dmemrd", dmemrd_mem, 0);
    chk("reset.misalign", {31'b0, misalign_mem}, 0);
    rst = 0;

    // Directed cases
    run_txn("sw_gnt0", 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, got);
    run_txn("sb_gnt1", 1, 3'b000, 32'h103, 32'h0000_00A5, 1, 0, 0, got);
    run_txn("lb", 0, 3'b000, 32'h102, 0, 0, 1, 32'h0080_0000, got);
    chk("lb.const", got, 32'hFFFF_FF80);
    run_txn("lbu", 0, 3'b100, 32'h102, 0, 0, 1, 32'h0080_0000, got);
    chk("lbu.const", got, 32'h0000_0080);
    run_txn("lh", 0, 3'b001, 32'h102, 0, 1, 2, 32'h8001_1234, got);
    chk("lh.const", got, 32'hFFFF_8001);
    run_txn("lhu", 0, 3'b101, 32'h102, 0, 0, 1, 32'h8001_1234, got);
    chk("lhu.const", got, 32'h0000_8001);

    // Store with read also asserted is a store
    @(negedge clk);
    memread_mem = 1; memwrite_mem = 1; funct3_mem = 3'b010;
    aluresult_mem = 32'h40; wdata_mem = 32'h1234_5678; dbus.dbus_gnt = 1;
    #1;
    chk("rw.we", {31'b0, dbus.dbus_we}, 1);
    chk("rw.stall", {31'b0, mem_stall}, 0);
    @(negedge clk); idle_inputs();

    // Flush in WAIT -> DRAIN until rvalid 3 cycles later
    @(negedge clk);
    memread_mem = 1; funct3_mem = 3'b010; aluresult_mem = 32'h200; dbus.dbus_gnt = 1;
    @(negedge clk);
    idle_inputs(); mem_flush = 1;
    #1;
    chk("drain.wait_stall", {31'b0, mem_stall}, 1);
    stalls = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      mem_flush = 0;
      dbus.dbus_rvalid = (c == 3);
      dbus.dbus_rdata = 32'hCAFE_F00D;
      #1;
      if (mem_stall) stalls++;
      chk("drain.rd_zero", dmemrd_mem, 0);
      chk("drain.req", {31'b0, dbus.dbus_req}, 0);
    end
    chk("drain.stalls", stalls, 3);
    @(negedge clk); idle_inputs(); #1;
    chk("drain.idle_stall", {31'b0, mem_stall}, 0);

    // Flush in REQ drops the request
    @(negedge clk);
    memread_mem = 1; funct3_mem = 3'b010; aluresult_mem = 32'h300;
    @(negedge clk);
    mem_flush = 1; #1;
    chk("reqflush.req", {31'b0, dbus.dbus_req}, 0);
    @(negedge clk); idle_inputs(); #1;
    chk("reqflush.idle_req", {31'b0, dbus.dbus_req}, 0);
    chk("reqflush.idle_stall", {31'b0, mem_stall}, 0);

    // Flush in IDLE issues nothing
    @(negedge clk);
    memwrite_mem = 1; funct3_mem = 3'b010; mem_flush = 1; #1;
    chk("idleflush.req", {31'b0, dbus.dbus_req}, 0);
    @(negedge clk); idle_inputs();

    // Stray rvalid in IDLE is ignored
    @(negedge clk);
    dbus.dbus_rvalid = 1; dbus.dbus_rdata = 32'hFFFF_FFFF; #1;
    chk("stray.dmemrd", dmemrd_mem, 0);
    chk("stray.stall", {31'b0, mem_stall}, 0);
    @(negedge clk); idle_inputs();

    // Reset mid-transaction; the late rvalid must be ignored
    @(negedge clk);
    memread_mem = 1; funct3_mem = 3'b010; aluresult_mem = 32'h400; dbus.dbus_gnt = 1;
    @(negedge clk);
    idle_inputs(); rst = 1;
    @(negedge clk);
    rst = 0; dbus.dbus_rvalid = 1; dbus.dbus_rdata = 32'h1111_2222; #1;
    chk("rstmid.dmemrd", dmemrd_mem, 0);
    chk("rstmid.stall", {31'b0, mem_stall}, 0);
    @(negedge clk); idle_inputs();

    // Misaligned word load
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    memread_mem = 1; funct3_mem = 3'b010; aluresult_mem = 32'h101; #1;
    chk("mis.flag", {31'b0, misalign_mem}, 1);
    chk("mis.req", {31'b0, dbus.dbus_req}, 0);
    chk("mis.stall", {31'b0, mem_stall}, 0);
    chk("mis.dmemrd", dmemrd_mem, 0);
    @(negedge clk);
    funct3_mem = 3'b001; aluresult_mem = 32'h103; memread_mem = 0; memwrite_mem = 1; #1;
    chk("mis.sh_flag", {31'b0, misalign_mem}, 1);
    chk("mis.sh_req", {31'b0, dbus.dbus_req}, 0);
    @(negedge clk); idle_inputs();
`else
    run_txn("lw_trunc", 0, 3'b010, 32'h101, 0, 0, 1, 32'h89AB_CDEF, got);
    chk("lw_trunc.const", got, 32'h89AB_CDEF);
`endif

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      int k = $urandom_range(0, 7);
      logic [31:0] a = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
      a = a & ~32'(m_size(ops_f3[k]) - 1);
`endif
      run_txn($sformatf("rnd%0d", i), ops_st[k], ops_f3[k], a, $urandom,
              $urandom_range(0, 3), $urandom_range(1, 3), $urandom, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
